// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target engine.
// Holds the FSM state encoding plus R/W and ACK/NACK bit values.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_WAIT_STOP
    } i2c_state_t;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;
    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with one-clk SCL edge and START/STOP pulses.
// Ports: clk, reset (async low), scl, sda in; sda_lvl, scl_rise, scl_fall, start, stop out.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic sda_lvl,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_sy;
    logic [1:0] sda_sy;
    logic       scl_h;
    logic       sda_h;

    // Pulses are registered so they line up with sda_lvl, three clk
    // after the pin edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sy   <= 2'b11;
            sda_sy   <= 2'b11;
            scl_h    <= 1'b1;
            sda_h    <= 1'b1;
            sda_lvl  <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            scl_sy   <= {scl_sy[0], scl};
            sda_sy   <= {sda_sy[0], sda};
            scl_h    <= scl_sy[1];
            sda_h    <= sda_sy[1];
            sda_lvl  <= sda_sy[1];
            scl_rise <= scl_sy[1] & ~scl_h;
            scl_fall <= ~scl_sy[1] & scl_h;
            start    <= scl_sy[1] & scl_h & sda_h & ~sda_sy[1];
            stop     <= scl_sy[1] & scl_h & ~sda_h & sda_sy[1];
        end
    end

endmodule

// File: rtl/i2c_target_regs.sv
// Register-mapped I2C target: address match, pointer, auto-increment R/W.
// Ports: clk, reset (async low), scl, sda (open drain), reg_* bus, busy.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    logic       sda_lvl;
    logic       scl_rise;
    logic       scl_fall;
    logic       start;
    logic       stop;

    i2c_state_t state;
    logic [2:0] bitcnt;
    logic [7:0] rx;
    logic [7:0] tx;
    logic [7:0] ptr;
    logic       rw;
    logic       ackd;
    logic       oe;
    logic       rd_go;
    logic       rd_cap;

    logic [7:0] rx_byte;
    logic       last_bit;

    i2c_line_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda      (sda),
        .sda_lvl  (sda_lvl),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign rx_byte  = {rx[6:0], sda_lvl};
    assign last_bit = (bitcnt == 3'd7);
    assign reg_addr = ptr;

    // Gating with reset releases the line immediately, not at the next edge.
    assign sda = (oe && reset) ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            bitcnt    <= 3'd0;
            rx        <= 8'h00;
            tx        <= 8'h00;
            ptr       <= 8'h00;
            rw        <= I2C_WRITE;
            ackd      <= 1'b0;
            oe        <= 1'b0;
            rd_go     <= 1'b0;
            rd_cap    <= 1'b0;
            reg_wdata <= 8'h00;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Read pipeline: request, then capture once the data is valid.
            reg_wr <= 1'b0;
            reg_rd <= rd_go;
            rd_go  <= 1'b0;
            rd_cap <= reg_rd;
            if (rd_cap)
                tx <= reg_rdata;
            if (reg_wr)
                ptr <= ptr + 8'd1;

            if (stop) begin
                state <= ST_IDLE;
                oe    <= 1'b0;
                busy  <= 1'b0;
                ackd  <= 1'b0;
            end else if (start) begin
                state  <= ST_ADDR;
                oe     <= 1'b0;
                bitcnt <= 3'd0;
                ackd   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_ADDR: if (scl_rise) begin
                        rx     <= rx_byte;
                        bitcnt <= bitcnt + 3'd1;
                        if (last_bit) begin
                            if (rx_byte[7:1] == SLAVE_ADDR &&
                                rx_byte[7:1] != 7'd0) begin
                                state <= ST_ADDR_ACK;
                                rw    <= rx_byte[0];
                                busy  <= 1'b1;
                                ackd  <= 1'b0;
                            end else begin
                                state <= ST_WAIT_STOP;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR_ACK: if (scl_fall) begin
                        if (!ackd) begin
                            oe   <= 1'b1;
                            ackd <= 1'b1;
                        end else begin
                            ackd   <= 1'b0;
                            bitcnt <= 3'd0;
                            if (rw == I2C_READ) begin
                                state <= ST_RDATA;
                                oe    <= ~tx[7];
                            end else begin
                                state <= ST_PTR;
                                oe    <= 1'b0;
                            end
                        end
                    end else if (scl_rise && ackd && rw == I2C_READ) begin
                        rd_go <= 1'b1;
                    end
                    ST_PTR: if (scl_rise) begin
                        rx     <= rx_byte;
                        bitcnt <= bitcnt + 3'd1;
                        if (last_bit) begin
                            ptr   <= rx_byte;
                            state <= ST_PTR_ACK;
                            ackd  <= 1'b0;
                        end
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                        if (!ackd) begin
                            oe   <= 1'b1;
                            ackd <= 1'b1;
                        end else begin
                            oe     <= 1'b0;
                            ackd   <= 1'b0;
                            bitcnt <= 3'd0;
                            state  <= ST_WDATA;
                        end
                    end
                    ST_WDATA: if (scl_rise) begin
                        rx     <= rx_byte;
                        bitcnt <= bitcnt + 3'd1;
                        if (last_bit) begin
                            reg_wr    <= 1'b1;
                            reg_wdata <= rx_byte;
                            state     <= ST_WDATA_ACK;
                            ackd      <= 1'b0;
                        end
                    end
                    ST_RDATA: if (scl_fall) begin
                        if (last_bit) begin
                            oe    <= 1'b0;
                            state <= ST_RDATA_ACK;
                            ackd  <= 1'b0;
                        end else begin
                            bitcnt <= bitcnt + 3'd1;
                            tx     <= {tx[6:0], 1'b0};
                            oe     <= ~tx[6];
                        end
                    end
                    ST_RDATA_ACK: if (scl_rise) begin
                        ptr <= ptr + 8'd1;
                        if (sda_lvl == I2C_ACK) begin
                            rd_go <= 1'b1;
                            ackd  <= 1'b1;
                        end else begin
                            state <= ST_WAIT_STOP;
                            busy  <= 1'b0;
                        end
                    end else if (scl_fall && ackd) begin
                        state  <= ST_RDATA;
                        bitcnt <= 3'd0;
                        oe     <= ~tx[7];
                        ackd   <= 1'b0;
                    end
                    ST_WAIT_STOP: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged master plus register file.
// Checks ACKs, write strobes, read data, pointer, busy and reset release.
module tb_i2c_target_regs;

    localparam time Q = 80;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    wire        sda;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;

    int n_asserts = 0;
    int n_fail = 0;

    logic [7:0] mem [256];
    int         wr_n = 0;
    int         rd_n = 0;
    logic [7:0] wr_a [16];
    logic [7:0] wr_d [16];
    logic [7:0] rd_a [16];

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_target_regs #(.SLAVE_ADDR(7'h50)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (reg_rd)
            reg_rdata <= mem[reg_addr];
        if (reg_wr) begin
            if (wr_n < 16) begin
                wr_a[wr_n] <= reg_addr;
                wr_d[wr_n] <= reg_wdata;
            end
            wr_n <= wr_n + 1;
        end
        if (reg_rd) begin
            if (rd_n < 16)
                rd_a[rd_n] <= reg_addr;
            rd_n <= rd_n + 1;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_start();
        m_low = 1'b0; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b1; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic m_stop();
        m_low = 1'b1; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b0; #(2 * Q);
    endtask

    task automatic m_bit(input logic b, output logic s);
        m_low = !b; #Q;
        scl = 1'b1; #Q;
        s = sda;    #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic m_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--)
            m_bit(d[i], s);
        m_bit(1'b1, ack);
    endtask

    task automatic m_read(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--)
            m_bit(1'b1, d[i]);
        m_bit(mack, s);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       a;
        logic [7:0] d;
        int         w0;
        int         r0;
        logic       s;

        for (int i = 0; i < 256; i++)
            mem[i] = 8'h00;
        mem[8'h20] = 8'h3C;
        mem[8'h21] = 8'hC3;

        repeat (5) @(posedge clk);
        #1;
        check("rst_sda", sda, 1'b1);
        check("rst_addr", reg_addr, 8'h00);
        check("rst_wdata", reg_wdata, 8'h00);
        check("rst_wr", reg_wr, 1'b0);
        check("rst_rd", reg_rd, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b1;
        #(2 * Q);

        // Single write
        m_start();
        m_byte(8'hA0, a); check("sw_ack_addr", a, 1'b0);
        check("sw_busy", busy, 1'b1);
        m_byte(8'h10, a); check("sw_ack_ptr", a, 1'b0);
        m_byte(8'hA5, a); check("sw_ack_data", a, 1'b0);
        m_stop();
        check("sw_wr_n", wr_n, 1);
        check("sw_wr_a", wr_a[0], 8'h10);
        check("sw_wr_d", wr_d[0], 8'hA5);
        check("sw_ptr", reg_addr, 8'h11);
        check("sw_busy_end", busy, 1'b0);

        // Burst write with pointer wrap
        m_start();
        m_byte(8'hA0, a); check("bw_ack_addr", a, 1'b0);
        m_byte(8'hFE, a); check("bw_ack_ptr", a, 1'b0);
        m_byte(8'h11, a); check("bw_ack_d0", a, 1'b0);
        m_byte(8'h22, a); check("bw_ack_d1", a, 1'b0);
        m_byte(8'h33, a); check("bw_ack_d2", a, 1'b0);
        m_stop();
        check("bw_wr_n", wr_n, 4);
        check("bw_a0", wr_a[1], 8'hFE);
        check("bw_d0", wr_d[1], 8'h11);
        check("bw_a1", wr_a[2], 8'hFF);
        check("bw_d1", wr_d[2], 8'h22);
        check("bw_a2", wr_a[3], 8'h00);
        check("bw_d2", wr_d[3], 8'h33);
        check("bw_ptr", reg_addr, 8'h01);

        // STOP after 4 data bits, then a normal write
        m_start();
        m_byte(8'hA0, a);
        m_byte(8'h40, a); check("sm_ack_ptr", a, 1'b0);
        m_bit(1'b1, s); m_bit(1'b0, s); m_bit(1'b1, s); m_bit(1'b1, s);
        m_stop();
        check("sm_wr_n", wr_n, 4);
        check("sm_ptr", reg_addr, 8'h40);
        check("sm_busy", busy, 1'b0);
        m_start();
        m_byte(8'hA0, a); check("sm2_ack_addr", a, 1'b0);
        m_byte(8'h41, a);
        m_byte(8'h5A, a); check("sm2_ack_data", a, 1'b0);
        m_stop();
        check("sm2_wr_n", wr_n, 5);
        check("sm2_a", wr_a[4], 8'h41);
        check("sm2_d", wr_d[4], 8'h5A);

        // Write pointer, repeated START, read two bytes
        r0 = rd_n;
        m_start();
        m_byte(8'hA0, a); check("wr_ack_addr", a, 1'b0);
        m_byte(8'h20, a); check("wr_ack_ptr", a, 1'b0);
        m_start();
        m_byte(8'hA1, a); check("rd_ack_addr", a, 1'b0);
        m_read(1'b0, d); check("rd_byte0", d, 8'h3C);
        m_read(1'b1, d); check("rd_byte1", d, 8'hC3);
        check("rd_busy_nack", busy, 1'b0);
        check("rd_sda_rel", sda, 1'b1);
        check("rd_n", rd_n - r0, 2);
        check("rd_a0", rd_a[r0], 8'h20);
        check("rd_a1", rd_a[r0 + 1], 8'h21);
        check("rd_ptr", reg_addr, 8'h22);
        check("rd_wr_n", wr_n, 5);
        m_stop();

        // Address mismatch
        w0 = wr_n;
        r0 = rd_n;
        m_start();
        m_byte(8'hA2, a); check("mm_nack", a, 1'b1);
        check("mm_busy", busy, 1'b0);
        m_byte(8'h00, a); check("mm_nack2", a, 1'b1);
        m_stop();
        check("mm_wr", wr_n - w0, 0);
        check("mm_rd", rd_n - r0, 0);

        // Reset while the target drives a 0 data bit
        m_start();
        m_byte(8'hA0, a);
        m_byte(8'h20, a);
        m_start();
        m_byte(8'hA1, a); check("rr_ack_addr", a, 1'b0);
        check("rr_drive0", sda, 1'b0);
        check("rr_busy_pre", busy, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rr_sda_rel", sda, 1'b1);
        check("rr_addr", reg_addr, 8'h00);
        check("rr_wdata", reg_wdata, 8'h00);
        check("rr_wr", reg_wr, 1'b0);
        check("rr_rd", reg_rd, 1'b0);
        check("rr_busy", busy, 1'b0);
        #20;
        reset = 1'b1;
        m_stop();
        check("rr_sda_idle", sda, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
